alu_result_display: RTL and testbench



---
 rtl/alu_result_display.sv | 157 +++++++++++++++
 tb/tb_alu_result_display.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// Shows a captured ALU result byte on one 7-segment display: high nibble (dp lit),
// low nibble, then a gap frame with an optional carry glyph, repeating until a new
// value arrives. Define LEAD_ZERO_BLANK_EN to blank a zero high nibble.
module alu_result_display #(
   parameter int unsigned DWELL_CYCLES = 10000000,
   parameter int unsigned GAP_CYCLES   = 2000000,
   parameter int unsigned CNT_W        = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_carry,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_done
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned SEG_W  = 7;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [SEG_W-1:0] CARRY_GLYPH = 7'h58;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHOW_HI = 2'd1,
      SHOW_LO = 2'd2,
      GAP     = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                carry_q, carry_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SEG_W-1:0]    seg_d;
   logic                dp_d;
   logic                frame_done_d;
   logic                accept;
   logic                hi_blank;

   function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nib);
      logic [SEG_W-1:0] g;
      case (nib)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   assign in_ready = (state_q == IDLE) || (state_q == GAP);
   assign accept   = in_valid & in_ready;

   // Next state, held value, dwell counter, and the output values for the next cycle.
   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      carry_d      = carry_q;
      cnt_d        = cnt_q;
      seg_d        = '0;
      dp_d         = 1'b0;
      frame_done_d = 1'b0;
      hi_blank     = 1'b0;

      case (state_q)
         SHOW_HI: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d   = '0;
               state_d = SHOW_LO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SHOW_LO: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d   = '0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = SHOW_HI;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase

      // A new value overrides every other transition, including the gap terminal count.
      if (accept) begin
         data_d  = in_data;
         carry_d = in_carry;
         cnt_d   = '0;
         state_d = SHOW_HI;
      end

`ifdef LEAD_ZERO_BLANK_EN
      hi_blank = (data_d[7:4] == 4'h0);
`else
      hi_blank = 1'b0;
`endif

      // Outputs are registered, so decode what the next cycle will display.
      case (state_d)
         SHOW_HI: begin
            seg_d = hi_blank ? '0 : hex_glyph(data_d[7:4]);
            dp_d  = 1'b1;
         end
         SHOW_LO: seg_d = hex_glyph(data_d[3:0]);
         GAP: begin
            seg_d        = carry_d ? CARRY_GLYPH : '0;
            frame_done_d = (cnt_d == GAP_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         data_q     <= '0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         seg        <= '0;
         dp         <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         seg        <= seg_d;
         dp         <= dp_d;
         frame_done <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_alu_result_display.sv
// Bench for alu_result_display: directed scenarios plus random traffic, checked
// every cycle against a frame-position model of the display sequence.
module tb_alu_result_display;

   localparam int unsigned D  = 4;
   localparam int unsigned G  = 2;
   localparam int unsigned FL = 2 * D + G;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_carry;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] seg;
   logic       dp;
   logic       frame_done;

   alu_result_display #(
      .DWELL_CYCLES(D),
      .GAP_CYCLES  (G),
      .CNT_W       (24)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_carry  (in_carry),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .seg       (seg),
      .dp        (dp),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: whether a value is held, and the position within the repeating frame.
   bit         m_active;
   int         m_pos;
   logic [7:0] m_data;
   bit         m_carry;
   bit         m_acc;

   logic [6:0] glyph_tab [16];
   bit         blank_lead;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   task automatic model_out(output logic [6:0] es, output logic ed, output logic ef,
                            output logic er);
      es = '0; ed = 1'b0; ef = 1'b0; er = 1'b1;
      if (m_active) begin
         if (m_pos < int'(D)) begin
            es = (blank_lead && m_data[7:4] == 4'h0) ? 7'h00 : glyph_tab[m_data[7:4]];
            ed = 1'b1;
            er = 1'b0;
         end else if (m_pos < int'(2 * D)) begin
            es = glyph_tab[m_data[3:0]];
            er = 1'b0;
         end else begin
            es = m_carry ? 7'h58 : 7'h00;
            ef = (m_pos == int'(FL) - 1);
         end
      end
   endtask

   // Compare current outputs, advance the model over the coming edge, then move to the next negedge.
   task automatic tick(input string tag);
      logic [6:0] es;
      logic ed, ef, er;
      model_out(es, ed, ef, er);
      check({tag, ".seg"}, 8'(seg), 8'(es));
      check({tag, ".dp"}, 8'(dp), 8'(ed));
      check({tag, ".frame_done"}, 8'(frame_done), 8'(ef));
      check({tag, ".in_ready"}, 8'(in_ready), 8'(er));
      m_acc = 1'b0;
      if (!rst_n) begin
         m_active = 1'b0; m_pos = 0; m_data = '0; m_carry = 1'b0;
      end else if (in_valid && er) begin
         m_active = 1'b1; m_pos = 0; m_data = in_data; m_carry = in_carry; m_acc = 1'b1;
      end else if (m_active) begin
         m_pos = (m_pos + 1) % int'(FL);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   // Offer a value until accepted, bounded by two full frames.
   task automatic send(input logic [7:0] d, input logic c);
      int i;
      in_data  = d;
      in_carry = c;
      in_valid = 1'b1;
      i = 0;
      m_acc = 1'b0;
      while (!m_acc && i < int'(2 * FL)) begin
         tick("send");
         i++;
      end
      in_valid = 1'b0;
      check("send.accepted_dp", 8'(dp), 8'(1));
   endtask

   initial begin
      glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef LEAD_ZERO_BLANK_EN
      blank_lead = 1'b1;
`else
      blank_lead = 1'b0;
`endif
      m_active = 1'b0; m_pos = 0; m_data = '0; m_carry = 1'b0; m_acc = 1'b0;

      // Reset with a pending producer value
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_carry = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ticks("reset", 3);
      rst_n = 1'b1; in_valid = 1'b0;
      ticks("idle", 2);

      // Basic frame and replay
      in_data = 8'hA7; in_carry = 1'b0; in_valid = 1'b1;
      tick("basic.acc");
      in_valid = 1'b0;
      check("basic.first_hi", 8'(seg), 8'h77);
      ticks("basic", int'(FL));
      check("basic.replay_hi", 8'(seg), 8'h77);

      // Carry glyph and back-pressure
      send(8'h3C, 1'b1);
      check("carry.hi", 8'(seg), 8'h4F);
      ticks("carry.hi", int'(D));
      in_data = 8'h11; in_carry = 1'b0; in_valid = 1'b1;
      check("bp.ready_lo", 8'(in_ready), 8'h00);
      ticks("bp.lo", int'(D));
      check("carry.gap_seg", 8'(seg), 8'h58);
      check("bp.ready_gap", 8'(in_ready), 8'h01);
      tick("bp.acc");
      in_valid = 1'b0;
      check("bp.new_hi", 8'(seg), 8'h06);
      check("bp.new_dp", 8'(dp), 8'h01);

      // Accept on the final gap cycle
      ticks("prio", int'(FL) - 1);
      in_data = 8'h5E; in_carry = 1'b0; in_valid = 1'b1;
      check("prio.frame_done", 8'(frame_done), 8'h01);
      tick("prio.acc");
      in_valid = 1'b0;
      check("prio.new_hi", 8'(seg), 8'h6D);

      // Reset during the low nibble
      send(8'h42, 1'b0);
      ticks("mrst.hi", int'(D));
      rst_n = 1'b0;
      tick("mrst.rst");
      rst_n = 1'b1;
      check("mrst.seg", 8'(seg), 8'h00);
      check("mrst.ready", 8'(in_ready), 8'h01);
      ticks("mrst.idle", int'(FL));

      // Leading zero
      send(8'h09, 1'b0);
      check("lz.hi_seg", 8'(seg), blank_lead ? 8'h00 : 8'h3F);
      ticks("lz.hi", int'(D));
      check("lz.lo_seg", 8'(seg), 8'h6F);
      ticks("lz.rest", int'(D + G));

      // Random traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         rst_n    = ($urandom_range(0, 99) != 0);
         in_valid = ($urandom_range(0, 2) == 0);
         in_data  = 8'($urandom);
         in_carry = 1'($urandom);
         tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
